// File: rtl/ac_motor_pkg.sv
// Shared definitions for the three-phase PWM datapath: state codes, default widths
// and the safe dead-time setting used by the sine, triangle and comparator blocks.
package ac_motor_pkg;

    localparam int FREQ_WIDTH = 12;
    localparam int AMP_WIDTH  = 12;
    localparam int DT_WIDTH   = 11;

    localparam logic [DT_WIDTH-1:0] DT_SAFE = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

endpackage

// File: rtl/ac_motor_vf_map.sv
// V/f law: amplitude = sat(BOOST + (freq * VF_GAIN) >> 8), forced to 0 at zero frequency.
module ac_motor_vf_map #(
    parameter int FREQ_W  = 12,
    parameter int AMP_W   = 12,
    parameter int VF_GAIN = 256,
    parameter int BOOST   = 0
) (
    input  logic [FREQ_W-1:0] freq_i,
    output logic [AMP_W-1:0]  amp_o
);

    localparam int PW = FREQ_W + 16;
    localparam logic [15:0] GAIN    = 16'(VF_GAIN);
    localparam logic [PW:0] BOOST_X = (PW+1)'(BOOST);
    localparam logic [PW:0] AMP_MAX = {{(PW+1-AMP_W){1'b0}}, {AMP_W{1'b1}}};

    logic [PW-1:0] prod;
    logic [PW:0]   sum;

    always_comb begin
        prod = PW'(freq_i) * PW'(GAIN);
        sum  = BOOST_X + (PW+1)'(prod >> 8);
        if (freq_i == '0) begin
            amp_o = '0;
        end else if (sum > AMP_MAX) begin
            amp_o = '1;
        end else begin
            amp_o = sum[AMP_W-1:0];
        end
    end

endmodule

// File: rtl/ac_motor_ramp_controller.sv
// Run-control sequencer: soft start/stop frequency ramp with V/f amplitude, lock-aligned updates.
// states: IDLE outputs off | RAMP stepping toward target | RUN at speed | STOP ramping to 0 | FAULT latched off
module ac_motor_ramp_controller
    import ac_motor_pkg::*;
#(
    parameter int FREQ_W  = FREQ_WIDTH,
    parameter int AMP_W   = AMP_WIDTH,
    parameter int DT_W    = DT_WIDTH,
    parameter int DIV_W   = 16,
    parameter int VF_GAIN = 256,
    parameter int BOOST   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              lock,
    input  logic              start,
    input  logic              fault,
    input  logic              fault_clr,
    input  logic [FREQ_W-1:0] target_freq,
    input  logic [7:0]        ramp_step,
    input  logic [DIV_W-1:0]  ramp_div,
    input  logic [DT_W-1:0]   dead_time_in,
    output logic [FREQ_W-1:0] frequency,
    output logic [AMP_W-1:0]  amplitude,
    output logic [DT_W-1:0]   dead_time,
    output logic              pwm_enable,
    output logic              at_speed,
    output logic [2:0]        state
);

    state_e            state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [AMP_W-1:0]  amp_q, amp_d;
    logic [DT_W-1:0]   dt_q, dt_d;
    logic              pwm_q, pwm_d;
    logic              at_q, at_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;

    logic [7:0]        step_eff;
    logic [FREQ_W-1:0] step_x;
    logic [DIV_W-1:0]  div_eff;
    logic [DIV_W-1:0]  cnt_inc;
    logic              tick;
    logic [FREQ_W-1:0] freq_ramp;
    logic [FREQ_W-1:0] freq_down;

    function automatic logic [FREQ_W-1:0] step_toward(input logic [FREQ_W-1:0] cur,
                                                      input logic [FREQ_W-1:0] tgt,
                                                      input logic [FREQ_W-1:0] stp);
        if (cur < tgt) begin
            return (tgt - cur <= stp) ? tgt : cur + stp;
        end else if (cur > tgt) begin
            return (cur - tgt <= stp) ? tgt : cur - stp;
        end
        return cur;
    endfunction

    assign step_eff  = (ramp_step == 8'd0) ? 8'd1 : ramp_step;
    assign step_x    = FREQ_W'(step_eff);
    assign div_eff   = (ramp_div == '0) ? DIV_W'(1) : ramp_div;
    assign cnt_inc   = cnt_q + DIV_W'(1);
    // compare one bit wider so a ramp_div lowered mid-count still ticks
    assign tick      = ((DIV_W+1)'(cnt_q) + (DIV_W+1)'(1)) >= (DIV_W+1)'(div_eff);
    assign freq_ramp = step_toward(freq_q, target_freq, step_x);
    assign freq_down = step_toward(freq_q, '0, step_x);

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        dt_d    = dt_q;
        pwm_d   = pwm_q;
        at_d    = at_q;
        cnt_d   = cnt_q;
        if (fault) begin
            state_d = ST_FAULT;
            freq_d  = '0;
            pwm_d   = 1'b0;
            at_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    freq_d = '0;
                    pwm_d  = 1'b0;
                    at_d   = 1'b0;
                    if (lock && start) begin
                        dt_d    = dead_time_in;
                        pwm_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: if (lock) begin
                    if (!start) begin
                        state_d = ST_STOP;
                        cnt_d   = '0;
                    end else if (tick) begin
                        cnt_d  = '0;
                        freq_d = freq_ramp;
                        if (freq_ramp == target_freq) begin
                            state_d = ST_RUN;
                            at_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RUN: if (lock) begin
                    dt_d = dead_time_in;
                    if (!start) begin
                        state_d = ST_STOP;
                        at_d    = 1'b0;
                        cnt_d   = '0;
                    end else if (target_freq != freq_q) begin
                        state_d = ST_RAMP;
                        at_d    = 1'b0;
                        cnt_d   = '0;
                    end
                end
                ST_STOP: if (lock) begin
                    if (start) begin
                        state_d = ST_RAMP;
                        cnt_d   = '0;
                    end else if (freq_q == '0) begin
                        pwm_d   = 1'b0;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        cnt_d  = '0;
                        freq_d = freq_down;
                        if (freq_down == '0) begin
                            pwm_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_FAULT: begin
                    freq_d = '0;
                    pwm_d  = 1'b0;
                    at_d   = 1'b0;
                    if (fault_clr && !start) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    ac_motor_vf_map #(
        .FREQ_W  (FREQ_W),
        .AMP_W   (AMP_W),
        .VF_GAIN (VF_GAIN),
        .BOOST   (BOOST)
    ) u_vf_map (
        .freq_i (freq_d),
        .amp_o  (amp_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            freq_q  <= '0;
            amp_q   <= '0;
            dt_q    <= DT_W'(DT_SAFE);
            pwm_q   <= 1'b0;
            at_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            dt_q    <= dt_d;
            pwm_q   <= pwm_d;
            at_q    <= at_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frequency  = freq_q;
    assign amplitude  = amp_q;
    assign dead_time  = dt_q;
    assign pwm_enable = pwm_q;
    assign at_speed   = at_q;
    assign state      = state_q;

endmodule

// File: tb/tb_ac_motor_ramp_controller.sv
// Directed bench for ac_motor_ramp_controller: unity-gain instance plus a boosted V/f instance on shared inputs.
module tb_ac_motor_ramp_controller;

    logic        clk;
    logic        reset_n;
    logic        lock;
    logic        start;
    logic        fault;
    logic        fault_clr;
    logic [11:0] target_freq;
    logic [7:0]  ramp_step;
    logic [15:0] ramp_div;
    logic [10:0] dead_time_in;

    logic [11:0] frequency, vf_frequency;
    logic [11:0] amplitude, vf_amplitude;
    logic [10:0] dead_time, vf_dead_time;
    logic        pwm_enable, vf_pwm_enable;
    logic        at_speed, vf_at_speed;
    logic [2:0]  state, vf_state;

    int n_checks = 0;
    int n_pass   = 0;

    int down_seq [4] = '{945, 690, 435, 300};

    ac_motor_ramp_controller u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lock         (lock),
        .start        (start),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .target_freq  (target_freq),
        .ramp_step    (ramp_step),
        .ramp_div     (ramp_div),
        .dead_time_in (dead_time_in),
        .frequency    (frequency),
        .amplitude    (amplitude),
        .dead_time    (dead_time),
        .pwm_enable   (pwm_enable),
        .at_speed     (at_speed),
        .state        (state)
    );

    ac_motor_ramp_controller #(.VF_GAIN(1024), .BOOST(100)) u_vf (
        .clk          (clk),
        .reset_n      (reset_n),
        .lock         (lock),
        .start        (start),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .target_freq  (target_freq),
        .ramp_step    (ramp_step),
        .ramp_div     (ramp_div),
        .dead_time_in (dead_time_in),
        .frequency    (vf_frequency),
        .amplitude    (vf_amplitude),
        .dead_time    (vf_dead_time),
        .pwm_enable   (vf_pwm_enable),
        .at_speed     (vf_at_speed),
        .state        (vf_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one carrier period: 99 idle clocks then a single-cycle lock; returns one
    // negedge after the lock edge so registered outputs are already updated
    task automatic do_lock();
        repeat (99) @(negedge clk);
        lock = 1'b1;
        @(negedge clk);
        lock = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        lock         = 1'b0;
        start        = 1'b0;
        fault        = 1'b0;
        fault_clr    = 1'b0;
        target_freq  = '0;
        ramp_step    = '0;
        ramp_div     = '0;
        dead_time_in = '0;
        repeat (3) @(negedge clk);

        check_val("rst_state", state, 0);
        check_val("rst_freq", frequency, 0);
        check_val("rst_amp", amplitude, 0);
        check_val("rst_dt", dead_time, 2047);
        check_val("rst_pwm", pwm_enable, 0);
        check_val("rst_at", at_speed, 0);
        check_val("rst_vf_state", vf_state, 0);
        check_val("rst_vf_dt", vf_dead_time, 2047);
        check_val("rst_vf_pwm", vf_pwm_enable, 0);
        check_val("rst_vf_at", vf_at_speed, 0);
        reset_n = 1'b1;

        // soft start 0 -> 1000, step 100, one tick per two locks
        target_freq  = 12'd1000;
        ramp_step    = 8'd100;
        ramp_div     = 16'd2;
        dead_time_in = 11'd50;
        start        = 1'b1;
        repeat (20) @(negedge clk);
        check_val("idle_pwm_before_lock", pwm_enable, 0);
        do_lock();
        check_val("start_state", state, 1);
        check_val("start_pwm", pwm_enable, 1);
        check_val("start_dt", dead_time, 50);
        check_val("start_freq", frequency, 0);
        for (int i = 1; i <= 20; i++) begin
            do_lock();
            check_val("ss_freq", frequency, 100 * (i / 2));
            check_val("ss_amp", amplitude, 100 * (i / 2));
            if (i == 10) check_val("vf_amp_500", vf_amplitude, 2100);
            if (i == 19) check_val("ss_state_19", state, 1);
        end
        check_val("ss_state_run", state, 2);
        check_val("ss_at_speed", at_speed, 1);
        repeat (50) @(negedge clk);
        check_val("ss_hold_freq", frequency, 1000);

        // raise to 1200, dead time re-latched in RUN, V/f saturation
        target_freq  = 12'd1200;
        ramp_div     = 16'd1;
        dead_time_in = 11'd77;
        do_lock();
        check_val("up_state_ramp", state, 1);
        check_val("up_at_clear", at_speed, 0);
        check_val("up_dt_relatch", dead_time, 77);
        check_val("up_freq_hold", frequency, 1000);
        do_lock();
        check_val("up_freq_1100", frequency, 1100);
        do_lock();
        check_val("up_freq_1200", frequency, 1200);
        check_val("up_state_run", state, 2);
        check_val("vf_freq_1200", vf_frequency, 1200);
        check_val("vf_amp_sat", vf_amplitude, 4095);
        check_val("amp_1200", amplitude, 1200);

        // ramp down to 300 with a clamped final step
        target_freq = 12'd300;
        ramp_step   = 8'd255;
        do_lock();
        check_val("dn_state_ramp", state, 1);
        for (int i = 0; i < 4; i++) begin
            do_lock();
            check_val("dn_freq", frequency, down_seq[i]);
        end
        check_val("dn_state_run", state, 2);

        // soft stop from 300
        ramp_step = 8'd100;
        start     = 1'b0;
        do_lock();
        check_val("stop_state", state, 3);
        check_val("stop_freq", frequency, 300);
        check_val("stop_at", at_speed, 0);
        do_lock();
        check_val("stop_freq_200", frequency, 200);
        do_lock();
        check_val("stop_freq_100", frequency, 100);
        check_val("stop_pwm_on", pwm_enable, 1);
        do_lock();
        check_val("stop_freq_0", frequency, 0);
        check_val("stop_amp_0", amplitude, 0);
        check_val("stop_pwm_off", pwm_enable, 0);
        check_val("stop_state_idle", state, 0);

        // non-multiple clamp 100, 200, 250 then lower target to 120
        target_freq  = 12'd250;
        dead_time_in = 11'd30;
        start        = 1'b1;
        do_lock();
        check_val("cl_dt", dead_time, 30);
        do_lock();
        check_val("cl_freq_100", frequency, 100);
        do_lock();
        check_val("cl_freq_200", frequency, 200);
        do_lock();
        check_val("cl_freq_250", frequency, 250);
        check_val("cl_state_run", state, 2);
        target_freq = 12'd120;
        do_lock();
        check_val("cl_lower_state", state, 1);
        do_lock();
        check_val("cl_freq_150", frequency, 150);
        do_lock();
        check_val("cl_freq_120", frequency, 120);
        check_val("cl_run_again", state, 2);
        check_val("cl_at_speed", at_speed, 1);

        // STOP -> RAMP keeps the dead time latched in RUN
        start        = 1'b0;
        dead_time_in = 11'd99;
        do_lock();
        check_val("rs_stop", state, 3);
        check_val("rs_dt_99", dead_time, 99);
        dead_time_in = 11'd111;
        start        = 1'b1;
        do_lock();
        check_val("rs_ramp", state, 1);
        check_val("rs_dt_kept", dead_time, 99);
        check_val("rs_freq", frequency, 120);
        do_lock();
        check_val("rs_run", state, 2);

        // fault mid-ramp between locks
        target_freq = 12'd600;
        do_lock();
        do_lock();
        check_val("ft_freq_220", frequency, 220);
        repeat (50) @(negedge clk);
        check_val("ft_pwm_before", pwm_enable, 1);
        fault = 1'b1;
        @(negedge clk);
        check_val("ft_pwm", pwm_enable, 0);
        check_val("ft_freq", frequency, 0);
        check_val("ft_amp", amplitude, 0);
        check_val("ft_state", state, 4);
        repeat (3) @(negedge clk);
        fault     = 1'b0;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check_val("ft_clr_start_hi", state, 4);
        start     = 1'b0;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check_val("ft_clr_idle", state, 0);

        // zero divider and zero step behave as 1
        ramp_div    = 16'd0;
        ramp_step   = 8'd0;
        target_freq = 12'd5;
        start       = 1'b1;
        do_lock();
        check_val("z_state", state, 1);
        for (int i = 1; i <= 3; i++) begin
            do_lock();
            check_val("z_freq", frequency, i);
        end

        // async reset mid-RAMP clears outputs without a clock edge
        repeat (30) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_val("ar_freq", frequency, 0);
        check_val("ar_amp", amplitude, 0);
        check_val("ar_pwm", pwm_enable, 0);
        check_val("ar_dt", dead_time, 2047);
        check_val("ar_state", state, 0);
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        do_lock();
        check_val("ar_idle_after", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
